// File: rtl/bfp16_multiplier.sv
// bfp16_multiplier: 3-cycle pipelined bfloat16 multiplier, RNE rounding, denormals flushed to zero
// Ports: clk, rst (async, active-high), stall (freezes every stage), in_valid/A/B (operand pair),
//        out_valid/O (registered product, valid 3 unstalled edges after the operands are sampled)
module bfp16_multiplier #(
  parameter int DATA_TYPE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 in_valid,
  input  logic [DATA_TYPE-1:0] A,
  input  logic [DATA_TYPE-1:0] B,
  output logic                 out_valid,
  output logic [DATA_TYPE-1:0] O
);
  logic [15:0] a_q, a_d, b_q, b_d;
  logic        v0_q, v0_d;
  logic        v1_q, v1_d, s1_q, s1_d, nan1_q, nan1_d, inf1_q, inf1_d, zero1_q, zero1_d;
  logic [9:0]  e1_q, e1_d;
  logic [15:0] p1_q, p1_d;
  logic        v2_q, v2_d, s2_q, s2_d, nan2_q, nan2_d, inf2_q, inf2_d, zero2_q, zero2_d;
  logic [9:0]  e2_q, e2_d;
  logic [6:0]  m2_q, m2_d;
  logic        v3_q, v3_d;
  logic [15:0] o_q, o_d;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        norm, guard, sticky;
  logic [6:0]  man;
  logic [7:0]  rnd;
  always_comb begin
    a_d     = A;
    b_d     = B;
    v0_d    = in_valid;
    a_zero  = a_q[14:7] == 8'h00;
    b_zero  = b_q[14:7] == 8'h00;
    a_inf   = (&a_q[14:7]) & ~(|a_q[6:0]);
    b_inf   = (&b_q[14:7]) & ~(|b_q[6:0]);
    a_nan   = (&a_q[14:7]) & (|a_q[6:0]);
    b_nan   = (&b_q[14:7]) & (|b_q[6:0]);
    v1_d    = v0_q;
    s1_d    = a_q[15] ^ b_q[15];
    e1_d    = {2'b0, a_q[14:7]} + {2'b0, b_q[14:7]} - 10'd127;
    p1_d    = {8'b0, 1'b1, a_q[6:0]} * {8'b0, 1'b1, b_q[6:0]};
    nan1_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    inf1_d  = a_inf | b_inf;
    zero1_d = a_zero | b_zero;
    norm    = p1_q[15];
    man     = norm ? p1_q[14:8] : p1_q[13:7];
    guard   = norm ? p1_q[7] : p1_q[6];
    sticky  = norm ? |p1_q[6:0] : |p1_q[5:0];
    // a carry out of the 7-bit mantissa leaves rnd[6:0] at zero, so only the exponent needs bumping
    rnd     = {1'b0, man} + {7'b0, guard & (sticky | man[0])};
    v2_d    = v1_q;
    s2_d    = s1_q;
    e2_d    = e1_q + {9'b0, norm} + {9'b0, rnd[7]};
    m2_d    = rnd[6:0];
    nan2_d  = nan1_q;
    inf2_d  = inf1_q;
    zero2_d = zero1_q;
    v3_d    = v2_q;
    o_d     = nan2_q                      ? 16'h7FC0 :
              inf2_q                      ? {s2_q, 8'hFF, 7'h0} :
              zero2_q                     ? {s2_q, 15'h0} :
              ($signed(e2_q) >= 10'sd255) ? {s2_q, 8'hFF, 7'h0} :
              ($signed(e2_q) <= 10'sd0)   ? {s2_q, 15'h0} :
                                            {s2_q, e2_q[7:0], m2_q};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; v0_q <= 1'b0;
      v1_q <= 1'b0; s1_q <= 1'b0; e1_q <= '0; p1_q <= '0; nan1_q <= 1'b0; inf1_q <= 1'b0; zero1_q <= 1'b0;
      v2_q <= 1'b0; s2_q <= 1'b0; e2_q <= '0; m2_q <= '0; nan2_q <= 1'b0; inf2_q <= 1'b0; zero2_q <= 1'b0;
      v3_q <= 1'b0; o_q <= '0;
    end else if (!stall) begin
      a_q <= a_d; b_q <= b_d; v0_q <= v0_d;
      v1_q <= v1_d; s1_q <= s1_d; e1_q <= e1_d; p1_q <= p1_d; nan1_q <= nan1_d; inf1_q <= inf1_d; zero1_q <= zero1_d;
      v2_q <= v2_d; s2_q <= s2_d; e2_q <= e2_d; m2_q <= m2_d; nan2_q <= nan2_d; inf2_q <= inf2_d; zero2_q <= zero2_d;
      v3_q <= v3_d; o_q <= o_d;
    end
  end
  assign out_valid = v3_q;
  assign O         = o_q;
endmodule
